// File: rtl/ecc_rmw_writer_cache_pkg.sv
// ecc_rmw_writer_cache_pkg: shared types and Hsiao SECDED helpers
// used by the ECC read-modify-write cache writer and its merge blocks.
package ecc_rmw_writer_cache_pkg;

    localparam int unsigned BlockWidth = 64;
    localparam int unsigned ProtWidth  = 8;
    localparam int unsigned EncWidth   = BlockWidth + ProtWidth;
    localparam int unsigned BlockBytes = BlockWidth / 8;

    typedef enum logic [1:0] {
        CovNone    = 2'd0,
        CovFull    = 2'd1,
        CovPartial = 2'd2
    } cov_e;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRead  = 2'd1,
        StMerge = 2'd2,
        StWrite = 2'd3
    } state_e;

    function automatic int unsigned popcnt(input logic [ProtWidth-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < int'(ProtWidth); i++) begin
            if (v[i]) n++;
        end
        return n;
    endfunction

    // Data-bit columns of the Hsiao matrix: every weight-3 column in
    // ascending order, then weight-5 columns until all data bits are
    // covered. Check bits use the weight-1 unit columns.
    function automatic logic [BlockWidth*ProtWidth-1:0] gen_hcols();
        logic [BlockWidth*ProtWidth-1:0] cols;
        int unsigned n;
        cols = '0;
        n    = 0;
        for (int unsigned w = 3; w <= 5; w += 2) begin
            for (int unsigned v = 0; v < 2**ProtWidth; v++) begin
                if (popcnt(v[ProtWidth-1:0]) == w && n < BlockWidth) begin
                    cols[n*ProtWidth +: ProtWidth] = v[ProtWidth-1:0];
                    n++;
                end
            end
        end
        return cols;
    endfunction

    localparam logic [BlockWidth*ProtWidth-1:0] HCols = gen_hcols();

    function automatic logic [ProtWidth-1:0] hsiao_parity(
        input logic [BlockWidth-1:0] d
    );
        logic [ProtWidth-1:0] p;
        p = '0;
        for (int i = 0; i < int'(BlockWidth); i++) begin
            if (d[i]) p ^= HCols[i*ProtWidth +: ProtWidth];
        end
        return p;
    endfunction

    function automatic cov_e classify(input logic [BlockBytes-1:0] be);
        if (be == '0) return CovNone;
        if (&be) return CovFull;
        return CovPartial;
    endfunction

endpackage

// File: rtl/ecc_rmw_merge.sv
// ecc_rmw_merge: per-block Hsiao correct, byte merge and re-encode.
// Purely combinational; the writer instantiates one per SECDED block.
module ecc_rmw_merge
    import ecc_rmw_writer_cache_pkg::*;
(
    input  cov_e                  i_cov,
    input  logic [EncWidth-1:0]   i_rdata,
    input  logic [BlockWidth-1:0] i_wdata,
    input  logic [BlockBytes-1:0] i_be,
    output logic [EncWidth-1:0]   o_enc,
    output logic                  o_corrected,
    output logic                  o_uncorrectable
);

    logic [ProtWidth-1:0]  w_syn;
    logic [BlockWidth-1:0] w_cor;
    logic [BlockWidth-1:0] w_data;
    logic                  w_hit;

    // syndrome decode; a column match flips that data bit
    always_comb begin
        w_syn = i_rdata[EncWidth-1 -: ProtWidth]
              ^ hsiao_parity(i_rdata[BlockWidth-1:0]);
        w_cor = i_rdata[BlockWidth-1:0];
        w_hit = $onehot(w_syn);
        for (int i = 0; i < int'(BlockWidth); i++) begin
            if (w_syn == HCols[i*ProtWidth +: ProtWidth]) begin
                w_cor[i] = ~w_cor[i];
                w_hit    = 1'b1;
            end
        end
    end

    // overlay enabled bytes on the corrected block and re-encode
    always_comb begin
        w_data = i_wdata;
        if (i_cov == CovPartial) begin
            for (int j = 0; j < int'(BlockBytes); j++) begin
                if (!i_be[j]) w_data[j*8 +: 8] = w_cor[j*8 +: 8];
            end
        end
        o_enc           = {hsiao_parity(w_data), w_data};
        o_corrected     = (i_cov == CovPartial) && (w_syn != '0) && w_hit;
        o_uncorrectable = (i_cov == CovPartial) && (w_syn != '0) && !w_hit;
    end

endmodule

// File: rtl/ecc_rmw_writer_cache.sv
// ecc_rmw_writer_cache: write-side SECDED front end for the cache banks.
// Full blocks are encoded directly, partial blocks are read-corrected-merged.
module ecc_rmw_writer_cache
    import ecc_rmw_writer_cache_pkg::*;
#(
    parameter  int unsigned DataWidth = 128,
    parameter  int unsigned AddrWidth = 8,
    parameter  int unsigned NrWays    = 2,
    localparam int unsigned NumBlocks = DataWidth / BlockWidth,
    localparam int unsigned LineWidth = NumBlocks * EncWidth
)(
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              req_valid_i,
    output logic                              req_ready_o,
    input  logic [NrWays-1:0]                 req_way_i,
    input  logic [AddrWidth-1:0]              req_addr_i,
    input  logic [DataWidth-1:0]              req_data_i,
    input  logic [DataWidth/8-1:0]            req_be_i,
    output logic                              done_o,
    output logic                              err_o,
    output logic                              bit_corrected_o,
    output logic                              uncorrectable_o,
    output logic [NrWays-1:0]                 bank_req_o,
    output logic                              bank_we_o,
    output logic [AddrWidth-1:0]              bank_addr_o,
    output logic [LineWidth-1:0]              bank_wdata_o,
    output logic [NumBlocks-1:0]              bank_be_o,
    input  logic                              bank_gnt_i,
    input  logic [NrWays-1:0][LineWidth-1:0]  bank_rdata_i
);

    state_e                 r_state;
    state_e                 w_next;
    logic [NrWays-1:0]      r_way;
    logic [AddrWidth-1:0]   r_addr;
    logic [DataWidth-1:0]   r_data;
    logic [DataWidth/8-1:0] r_be;
    logic [LineWidth-1:0]   r_wline;
    logic                   r_zero_done;

    logic                   w_idle;
    logic                   w_accept;
    logic [DataWidth-1:0]   w_data_sel;
    logic [DataWidth/8-1:0] w_be_sel;
    logic [LineWidth-1:0]   w_rline;
    logic [LineWidth-1:0]   w_enc_line;
    logic [NumBlocks-1:0]   w_partial;
    logic [NumBlocks-1:0]   w_blk_en;
    logic [NumBlocks-1:0]   w_cor;
    logic [NumBlocks-1:0]   w_unc;
    cov_e                   w_cov [NumBlocks];

    assign w_idle     = (r_state == StIdle);
    assign w_accept   = w_idle && req_valid_i;
    assign w_data_sel = w_idle ? req_data_i : r_data;
    assign w_be_sel   = w_idle ? req_be_i : r_be;

    // stored line of the registered target way
    always_comb begin
        w_rline = '0;
        for (int w = 0; w < int'(NrWays); w++) begin
            if (r_way[w]) w_rline = w_rline | bank_rdata_i[w];
        end
    end

    // block coverage: live request in Idle, registered request otherwise
    always_comb begin
        w_partial = '0;
        w_blk_en  = '0;
        for (int b = 0; b < int'(NumBlocks); b++) begin
            w_cov[b]     = classify(w_be_sel[b*BlockBytes +: BlockBytes]);
            w_partial[b] = (w_cov[b] == CovPartial);
            w_blk_en[b]  = |r_be[b*BlockBytes +: BlockBytes];
        end
    end

    for (genvar b = 0; b < NumBlocks; b++) begin : g_blk
        ecc_rmw_merge u_merge (
            .i_cov           (w_cov[b]),
            .i_rdata         (w_rline[b*EncWidth +: EncWidth]),
            .i_wdata         (w_data_sel[b*BlockWidth +: BlockWidth]),
            .i_be            (w_be_sel[b*BlockBytes +: BlockBytes]),
            .o_enc           (w_enc_line[b*EncWidth +: EncWidth]),
            .o_corrected     (w_cor[b]),
            .o_uncorrectable (w_unc[b])
        );
    end

    // state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_next;
        end
    end

    // request capture; encoded line loaded on accept and after merge
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_way       <= '0;
            r_addr      <= '0;
            r_data      <= '0;
            r_be        <= '0;
            r_wline     <= '0;
            r_zero_done <= 1'b0;
        end else begin
            r_zero_done <= w_accept && (req_be_i == '0);
            if (w_accept) begin
                r_way   <= req_way_i;
                r_addr  <= req_addr_i;
                r_data  <= req_data_i;
                r_be    <= req_be_i;
                r_wline <= w_enc_line;
            end else if (r_state == StMerge) begin
                r_wline <= w_enc_line;
            end
        end
    end

    // next state and bank/status outputs
    always_comb begin
        w_next          = r_state;
        req_ready_o     = 1'b0;
        done_o          = r_zero_done;
        err_o           = 1'b0;
        bit_corrected_o = 1'b0;
        uncorrectable_o = 1'b0;
        bank_req_o      = '0;
        bank_we_o       = 1'b0;
        bank_addr_o     = '0;
        bank_wdata_o    = '0;
        bank_be_o       = '0;
        unique case (r_state)
            StIdle: begin
                req_ready_o = 1'b1;
                if (req_valid_i && (req_be_i != '0)) begin
                    w_next = (|w_partial) ? StRead : StWrite;
                end
            end
            StRead: begin
                bank_req_o  = r_way;
                bank_addr_o = r_addr;
                if (bank_gnt_i) w_next = StMerge;
            end
            StMerge: begin
                if (|w_unc) begin
                    uncorrectable_o = 1'b1;
                    done_o          = 1'b1;
                    err_o           = 1'b1;
                    w_next          = StIdle;
                end else begin
                    bit_corrected_o = |w_cor;
                    w_next          = StWrite;
                end
            end
            StWrite: begin
                bank_req_o   = r_way;
                bank_we_o    = 1'b1;
                bank_addr_o  = r_addr;
                bank_wdata_o = r_wline;
                bank_be_o    = w_blk_en;
                if (bank_gnt_i) begin
                    done_o = 1'b1;
                    w_next = StIdle;
                end
            end
            default: w_next = StIdle;
        endcase
    end

endmodule

// File: tb/tb_ecc_rmw_writer_cache.sv
// tb_ecc_rmw_writer_cache: directed and random requests against a
// line-level reference of the bank contents and injected errors.
module tb_ecc_rmw_writer_cache;

    logic                clk = 1'b0;
    logic                rst_ni = 1'b0;
    logic                req_valid = 1'b0;
    logic                req_ready;
    logic [1:0]          req_way = '0;
    logic [7:0]          req_addr = '0;
    logic [127:0]        req_data = '0;
    logic [15:0]         req_be = '0;
    logic                done, err, cor, unc;
    logic [1:0]          bank_req;
    logic                bank_we;
    logic [7:0]          bank_addr;
    logic [143:0]        bank_wdata;
    logic [1:0]          bank_be;
    logic                gnt = 1'b0;
    logic [1:0][143:0]   bank_rdata = '0;

    logic [7:0]  hcol [64];
    logic [63:0] gold [2][256][2];
    logic [71:0] mem  [2][256][2];
    int          inj  [2][256][2];
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    ecc_rmw_writer_cache dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .req_way_i       (req_way),
        .req_addr_i      (req_addr),
        .req_data_i      (req_data),
        .req_be_i        (req_be),
        .done_o          (done),
        .err_o           (err),
        .bit_corrected_o (cor),
        .uncorrectable_o (unc),
        .bank_req_o      (bank_req),
        .bank_we_o       (bank_we),
        .bank_addr_o     (bank_addr),
        .bank_wdata_o    (bank_wdata),
        .bank_be_o       (bank_be),
        .bank_gnt_i      (gnt),
        .bank_rdata_i    (bank_rdata)
    );

    function automatic logic [71:0] enc(input logic [63:0] d);
        logic [7:0] p;
        p = '0;
        for (int i = 0; i < 64; i++) if (d[i]) p = p ^ hcol[i];
        return {p, d};
    endfunction

    task automatic chk(input string tag, input logic [143:0] obs,
                       input logic [143:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ready"}, 144'(req_ready), 144'(1));
        chk({tag, "_done"}, 144'(done), 144'(0));
        chk({tag, "_err"}, 144'(err), 144'(0));
        chk({tag, "_cor"}, 144'(cor), 144'(0));
        chk({tag, "_unc"}, 144'(unc), 144'(0));
        chk({tag, "_breq"}, 144'(bank_req), 144'(0));
        chk({tag, "_we"}, 144'(bank_we), 144'(0));
    endtask

    // kinds: 0 read wait, 1 read grant, 2 merge, 3 write wait,
    // 4 write grant, 5 zero-enable completion
    task automatic run_req(input int way, input int addr,
                           input logic [127:0] data, input logic [15:0] be,
                           input int rd_stall, input int wr_stall);
        int          kind [$];
        int          cv [2];
        logic [7:0]  bb;
        logic [63:0] raw [2];
        logic [1:0]  exp_be;
        logic [1:0]  oh;
        logic [143:0] exp_w, mask;
        bit          any_p, c1, exp_unc, exp_cor;
        oh = 2'b01 << way;
        any_p = 0; c1 = 0; exp_unc = 0;
        for (int b = 0; b < 2; b++) begin
            bb = be[b*8 +: 8];
            cv[b] = (bb == 8'h00) ? 0 : (bb == 8'hFF) ? 1 : 2;
            for (int j = 0; j < 8; j++)
                raw[b][j*8 +: 8] = bb[j] ? data[b*64 + j*8 +: 8]
                                         : gold[way][addr][b][j*8 +: 8];
            exp_be[b] = (cv[b] != 0);
            if (cv[b] == 2) begin
                any_p = 1;
                if (inj[way][addr][b] == 2) exp_unc = 1;
                if (inj[way][addr][b] == 1) c1 = 1;
            end
        end
        exp_cor = c1 && !exp_unc;
        exp_w = {enc(raw[1]), enc(raw[0])};
        mask  = {{72{exp_be[1]}}, {72{exp_be[0]}}};
        if (be == '0) kind.push_back(5);
        else begin
            if (any_p) begin
                repeat (rd_stall) kind.push_back(0);
                kind.push_back(1);
                kind.push_back(2);
            end
            if (!exp_unc) begin
                repeat (wr_stall) kind.push_back(3);
                kind.push_back(4);
            end
        end
        req_valid = 1; req_way = oh; req_addr = 8'(addr);
        req_data = data; req_be = be; gnt = 0;
        #1 chk("acc_ready", 144'(req_ready), 144'(1));
        @(posedge clk); #1;
        req_valid = 0;
        req_data = {$urandom, $urandom, $urandom, $urandom};
        req_be = 16'($urandom);
        foreach (kind[k]) begin
            gnt = (kind[k] == 1 || kind[k] == 4);
            #1;
            case (kind[k])
                0, 1: begin
                    chk("rd_req", 144'(bank_req), 144'(oh));
                    chk("rd_we", 144'(bank_we), 144'(0));
                    chk("rd_addr", 144'(bank_addr), 144'(addr));
                    chk("rd_ready", 144'(req_ready), 144'(0));
                    chk("rd_done", 144'(done), 144'(0));
                end
                2: begin
                    chk("mg_req", 144'(bank_req), 144'(0));
                    chk("mg_cor", 144'(cor), 144'(exp_cor));
                    chk("mg_unc", 144'(unc), 144'(exp_unc));
                    chk("mg_done", 144'(done), 144'(exp_unc));
                    chk("mg_err", 144'(err), 144'(exp_unc));
                end
                3, 4: begin
                    chk("wr_req", 144'(bank_req), 144'(oh));
                    chk("wr_we", 144'(bank_we), 144'(1));
                    chk("wr_addr", 144'(bank_addr), 144'(addr));
                    chk("wr_be", 144'(bank_be), 144'(exp_be));
                    chk("wr_data", bank_wdata & mask, exp_w & mask);
                    chk("wr_done", 144'(done), 144'(kind[k] == 4));
                    chk("wr_err", 144'(err), 144'(0));
                end
                default: begin
                    chk("z_done", 144'(done), 144'(1));
                    chk("z_err", 144'(err), 144'(0));
                    chk("z_breq", 144'(bank_req), 144'(0));
                end
            endcase
            if (kind[k] == 1) begin
                bank_rdata[0] = {mem[0][addr][1], mem[0][addr][0]};
                bank_rdata[1] = {mem[1][addr][1], mem[1][addr][0]};
            end
            if (kind[k] == 4) begin
                for (int b = 0; b < 2; b++)
                    if (bank_be[b]) mem[way][addr][b] = bank_wdata[b*72 +: 72];
            end
            @(posedge clk); #1;
        end
        gnt = 0;
        #1 chk_idle("post");
        if (be != '0 && !exp_unc) begin
            for (int b = 0; b < 2; b++) begin
                if (exp_be[b]) begin
                    gold[way][addr][b] = raw[b];
                    inj[way][addr][b] = 0;
                end
            end
        end
    endtask

    initial begin
        int n;
        int way, addr, p1, p2, blk, nf;
        logic [15:0] be;
        n = 0;
        for (int w = 3; w <= 5; w += 2)
            for (int v = 0; v < 256; v++)
                if ($countones(8'(v)) == w && n < 64) begin
                    hcol[n] = 8'(v);
                    n++;
                end
        for (int w = 0; w < 2; w++)
            for (int a = 0; a < 256; a++)
                for (int b = 0; b < 2; b++) begin
                    gold[w][a][b] = (w == 0) ? 64'hA5A5_A5A5_A5A5_A5A5
                                             : {$urandom, $urandom};
                    mem[w][a][b] = enc(gold[w][a][b]);
                    inj[w][a][b] = 0;
                end

        // reset values
        #3;
        chk_idle("rst");
        chk("rst_addr", 144'(bank_addr), 144'(0));
        chk("rst_wdata", bank_wdata, 144'(0));
        chk("rst_be", 144'(bank_be), 144'(0));
        repeat (2) @(posedge clk);
        #2 rst_ni = 1;

        // full write, clean partial write
        run_req(0, 1, {$urandom, $urandom, $urandom, $urandom}, 16'hFFFF, 0, 0);
        run_req(0, 2, {$urandom, $urandom, $urandom, $urandom}, 16'h000F, 0, 0);

        // single-bit error, bit 5 kept from the stored line
        mem[0][3][0][5] ^= 1'b1; inj[0][3][0] = 1;
        run_req(0, 3, {$urandom, $urandom, $urandom, $urandom}, 16'h00F0, 0, 0);
        chk("cor_bit5", 144'(mem[0][3][0][5]), 144'(1));

        // double-bit error, no write
        mem[0][4][0][3] ^= 1'b1; mem[0][4][0][9] ^= 1'b1; inj[0][4][0] = 2;
        run_req(0, 4, {$urandom, $urandom, $urandom, $urandom}, 16'h00F0, 0, 0);
        chk("unc_nowr", 144'(mem[0][4][0]),
            144'(enc(gold[0][4][0]) ^ 72'h208));
        mem[0][4][0] = enc(gold[0][4][0]); inj[0][4][0] = 0;

        // grant stalls, zero enables
        run_req(1, 6, {$urandom, $urandom, $urandom, $urandom}, 16'hFF0F, 3, 2);
        run_req(1, 7, {$urandom, $urandom, $urandom, $urandom}, 16'h0000, 0, 0);

        // errors in full/none blocks go unnoticed; parity-bit error
        mem[1][8][1][20] ^= 1'b1; inj[1][8][1] = 1;
        run_req(1, 8, {$urandom, $urandom, $urandom, $urandom}, 16'hFF03, 0, 0);
        mem[0][9][1][7] ^= 1'b1; inj[0][9][1] = 1;
        run_req(0, 9, {$urandom, $urandom, $urandom, $urandom}, 16'h0003, 0, 1);
        run_req(0, 9, {$urandom, $urandom, $urandom, $urandom}, 16'h0100, 1, 0);
        mem[0][10][0][68] ^= 1'b1; inj[0][10][0] = 1;
        run_req(0, 10, {$urandom, $urandom, $urandom, $urandom}, 16'h0001, 0, 0);

        // reset in the merge cycle
        mem[0][11][0][12] ^= 1'b1; inj[0][11][0] = 1;
        req_valid = 1; req_way = 2'b01; req_addr = 8'd11;
        req_data = {$urandom, $urandom, $urandom, $urandom}; req_be = 16'h0010;
        @(posedge clk); #1;
        req_valid = 0; gnt = 1;
        #1;
        bank_rdata[0] = {mem[0][11][1], mem[0][11][0]};
        @(posedge clk); #1;
        gnt = 0;
        #1 chk("rm_cor", 144'(cor), 144'(1));
        rst_ni = 0;
        #1 chk_idle("rm_rst");
        @(posedge clk);
        #2 rst_ni = 1;
        #1 chk_idle("rm_rel");
        @(posedge clk);
        #2 chk_idle("rm_rel2");
        run_req(0, 11, {$urandom, $urandom, $urandom, $urandom}, 16'h0010, 0, 0);

        // random traffic
        for (int it = 0; it < 60; it++) begin
            way  = $urandom_range(0, 1);
            addr = $urandom_range(0, 7);
            for (int b = 0; b < 2; b++) begin
                case ($urandom_range(0, 2))
                    0: be[b*8 +: 8] = 8'h00;
                    1: be[b*8 +: 8] = 8'hFF;
                    default: be[b*8 +: 8] = 8'($urandom_range(1, 254));
                endcase
            end
            if ($urandom_range(0, 2) == 0) begin
                blk = $urandom_range(0, 1);
                if (inj[way][addr][blk] == 0) begin
                    nf = $urandom_range(1, 2);
                    p1 = $urandom_range(0, 71);
                    p2 = (p1 + $urandom_range(1, 71)) % 72;
                    mem[way][addr][blk][p1] ^= 1'b1;
                    if (nf == 2) mem[way][addr][blk][p2] ^= 1'b1;
                    inj[way][addr][blk] = nf;
                end
            end
            run_req(way, addr, {$urandom, $urandom, $urandom, $urandom}, be,
                    $urandom_range(0, 2), $urandom_range(0, 2));
        end

        // final bank contents of clean blocks
        for (int w = 0; w < 2; w++)
            for (int a = 0; a < 12; a++)
                for (int b = 0; b < 2; b++)
                    if (inj[w][a][b] == 0)
                        chk("mem", 144'(mem[w][a][b]), 144'(enc(gold[w][a][b])));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
